// File: rtl/sev_seg_scan_ctrl.sv
// sev_seg_scan_ctrl
// Time-multiplexed seven-segment scan controller for NUM_DIGITS digits.
// Digit values, decimal points and digit enables are captured into shadow
// registers on a load strobe. Each digit dwells for 2^REFRESH_LOG2 cycles.
// Within the dwell, the anode is held off for the first cycle so adjacent
// digits never overlap. A PWM window selected by 'bright' gates the rest of
// the dwell. A one-cycle 'frame' pulse marks every wrap back to digit 0.
// seg, dp and an are registered, so they show last cycle's scan state.
//
// Optional feature: define SEV_SEG_LZB_EN to build leading-zero blanking,
// which is then controlled by 'blank_zero'. When the macro is undefined,
// 'blank_zero' is ignored.

module sev_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_LOG2 = 17,
    parameter int BRIGHT_W     = 3
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   en_in,
    input  logic [BRIGHT_W-1:0]     bright,
    input  logic                    blank_zero,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_en;

    logic [REFRESH_LOG2-1:0] cnt;
    logic [IDX_W-1:0]        idx;

    logic [NUM_DIGITS-1:0]   blank;
    logic [3:0]              cur_nibble;
    logic [6:0]              seg_dec;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_next;
    logic                    dp_next;

    // Shadow registers: all three update together on the load strobe only
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_en     <= '0;
        end else if (load) begin
            sh_digits <= digits_in;
            sh_dp     <= dp_in;
            sh_en     <= en_in;
        end
    end

    // Dwell counter and digit index; frame flags the cycle idx returns to 0
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            idx   <= '0;
            frame <= 1'b0;
        end else begin
            cnt   <= cnt + 1'b1;
            frame <= (&cnt) && (idx == LAST_IDX);
            if (&cnt) begin
                if (idx == LAST_IDX) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

`ifdef SEV_SEG_LZB_EN
    logic zero_from_top;

    // Blank digit k (k >= 1) when it and every digit above it hold zero
    always_comb begin
        blank         = '0;
        zero_from_top = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_from_top = zero_from_top & (sh_digits[4*k +: 4] == 4'h0);
            blank[k]      = blank_zero & zero_from_top;
        end
    end
`else
    logic unused_blank_zero;

    assign unused_blank_zero = blank_zero;
    assign blank             = '0;
`endif

    // Hex to active-low segment decode of the currently selected digit
    always_comb begin
        cur_nibble = sh_digits[{idx, 2'b00} +: 4];
        seg_dec    = 7'h7F;
        case (cur_nibble)
            4'h0: seg_dec = 7'h40;
            4'h1: seg_dec = 7'h79;
            4'h2: seg_dec = 7'h24;
            4'h3: seg_dec = 7'h30;
            4'h4: seg_dec = 7'h19;
            4'h5: seg_dec = 7'h12;
            4'h6: seg_dec = 7'h02;
            4'h7: seg_dec = 7'h78;
            4'h8: seg_dec = 7'h00;
            4'h9: seg_dec = 7'h10;
            4'hA: seg_dec = 7'h08;
            4'hB: seg_dec = 7'h03;
            4'hC: seg_dec = 7'h46;
            4'hD: seg_dec = 7'h21;
            4'hE: seg_dec = 7'h06;
            4'hF: seg_dec = 7'h0E;
            default: seg_dec = 7'h7F;
        endcase
    end

    // Anode gating: enabled, past the dead cycle, inside the PWM window, not blanked
    always_comb begin
        lit = sh_en[idx]
              && (cnt != '0)
              && (cnt[REFRESH_LOG2-1 -: BRIGHT_W] <= bright)
              && !blank[idx];

        an_next  = '1;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (lit) begin
            an_next[idx] = 1'b0;
            seg_next     = seg_dec;
            dp_next      = ~sh_dp[idx];
        end
    end

    // Registered pin drivers, all off in reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            seg <= 7'h7F;
            dp  <= 1'b1;
            an  <= '1;
        end else begin
            seg <= seg_next;
            dp  <= dp_next;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// tb_sev_seg_scan_ctrl
// Directed bench for sev_seg_scan_ctrl with NUM_DIGITS=8, REFRESH_LOG2=4
// and BRIGHT_W=2. Each digit dwells 16 cycles and a full scan is 128 cycles.
// Both builds are checked: with and without SEV_SEG_LZB_EN.

module tb_sev_seg_scan_ctrl;

    localparam int ND = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          load;
    logic [31:0]   digits_in;
    logic [7:0]    dp_in;
    logic [7:0]    en_in;
    logic [1:0]    bright;
    logic          blank_zero;
    logic [6:0]    seg;
    logic          dp;
    logic [7:0]    an;
    logic          frame;

    int            checks = 0;
    int            errors = 0;
    int            edge_n = 0;

    logic [31:0]   exp_digits;
    int            low_cnt [ND];
    int            dp_low [ND];
    int            dp_orphan;
    int            seg_bad;
    int            frames;

    sev_seg_scan_ctrl #(
        .NUM_DIGITS  (8),
        .REFRESH_LOG2(4),
        .BRIGHT_W    (2)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .load      (load),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .en_in     (en_in),
        .bright    (bright),
        .blank_zero(blank_zero),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .frame     (frame)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [6:0] hexSeg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] d, input logic [7:0] p,
                                 input logic [7:0] e, input logic [1:0] b, input logic z);
        digits_in  = d;
        dp_in      = p;
        en_in      = e;
        bright     = b;
        blank_zero = z;
        exp_digits = d;
    endtask

    task automatic applyReset(input logic with_load);
        resetn = 1'b0;
        load   = with_load;
        #1;
        @(negedge clk);
        resetn = 1'b1;
        edge_n = 0;
    endtask

    task automatic stepTo(input int target);
        while (edge_n < target) begin
            @(posedge clk);
            #1;
            edge_n++;
        end
    endtask

    task automatic pulseLoad();
        load = 1'b1;
        stepTo(edge_n + 1);
        load = 1'b0;
    endtask

    task automatic measureWindow(input int n);
        int nlow;
        int lowk;
        for (int k = 0; k < ND; k++) begin
            low_cnt[k] = 0;
            dp_low[k]  = 0;
        end
        dp_orphan = 0;
        seg_bad   = 0;
        frames    = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            edge_n++;
            if (frame) frames++;
            nlow = 0;
            lowk = 0;
            for (int k = 0; k < ND; k++) begin
                if (!an[k]) begin
                    nlow++;
                    lowk = k;
                    low_cnt[k]++;
                    if (!dp) dp_low[k]++;
                end
            end
            if (nlow == 0) begin
                if (seg !== 7'h7F || dp !== 1'b1) seg_bad++;
                if (!dp) dp_orphan++;
            end else if (nlow > 1) begin
                seg_bad++;
            end else if (seg !== hexSeg(exp_digits[4*lowk +: 4])) begin
                seg_bad++;
            end
        end
    endtask

    task automatic checkLows(input string tag, input logic [7:0] lit_mask, input logic [7:0] dp_mask);
        for (int k = 0; k < ND; k++) begin
            checkOutput($sformatf("%s_an%0d", tag, k), low_cnt[k], lit_mask[k] ? 15 : 0);
            checkOutput($sformatf("%s_dp%0d", tag, k), dp_low[k], dp_mask[k] ? 15 : 0);
        end
        checkOutput({tag, "_dp_orphan"}, dp_orphan, 0);
        checkOutput({tag, "_seg"}, seg_bad, 0);
        checkOutput({tag, "_frames"}, frames, 1);
    endtask

    initial begin
        resetn = 1'b0;
        load   = 1'b0;
        applyStimulus(32'h76543210, 8'h00, 8'hFF, 2'd3, 1'b0);
        #23;
        checkOutput("rst_an", an, 8'hFF);
        checkOutput("rst_seg", seg, 7'h7F);
        checkOutput("rst_dp", dp, 1'b1);
        checkOutput("rst_frame", frame, 1'b0);

        // Basic scan after release with load on the first edge
        applyReset(1'b1);
        stepTo(1);
        load = 1'b0;
        checkOutput("e1_an", an, 8'hFF);
        stepTo(2);
        checkOutput("e2_an", an, 8'hFE);
        checkOutput("e2_seg", seg, 7'h40);
        checkOutput("e2_dp", dp, 1'b1);
        stepTo(16);
        checkOutput("e16_an", an, 8'hFE);
        stepTo(17);
        checkOutput("dead_an", an, 8'hFF);
        checkOutput("dead_seg", seg, 7'h7F);
        stepTo(18);
        checkOutput("e18_an", an, 8'hFD);
        checkOutput("e18_seg", seg, 7'h79);
        stepTo(83);
        checkOutput("e83_an", an, 8'hDF);
        checkOutput("e83_seg", seg, 7'h12);
        stepTo(127);
        checkOutput("e127_frame", frame, 1'b0);
        stepTo(128);
        checkOutput("e128_frame", frame, 1'b1);
        stepTo(129);
        checkOutput("e129_frame", frame, 1'b0);

        // Input change without load must not reach the display
        stepTo(256);
        applyStimulus(32'h76543210, 8'h00, 8'hFF, 2'd3, 1'b0);
        digits_in = 32'hFFFFFFFF;
        stepTo(258);
        checkOutput("noload_an", an, 8'hFE);
        checkOutput("noload_seg", seg, 7'h40);
        load = 1'b1;
        stepTo(259);
        load = 1'b0;
        exp_digits = 32'hFFFFFFFF;
        checkOutput("loadedge_seg", seg, 7'h40);
        stepTo(260);
        checkOutput("loaded_seg", seg, 7'h0E);

        // PWM: bright=0 lights cnt 1..3, bright=1 lights cnt 1..7
        bright = 2'd0;
        stepTo(261);
        checkOutput("b0_cnt4", an, 8'hFF);
        stepTo(273);
        checkOutput("b0_cnt0", an, 8'hFF);
        stepTo(274);
        checkOutput("b0_cnt1", an, 8'hFD);
        stepTo(276);
        checkOutput("b0_cnt3", an, 8'hFD);
        checkOutput("b0_cnt3_seg", seg, 7'h0E);
        stepTo(277);
        checkOutput("b0_cnt4b", an, 8'hFF);
        bright = 2'd1;
        stepTo(280);
        checkOutput("b1_cnt7", an, 8'hFD);
        stepTo(281);
        checkOutput("b1_cnt8", an, 8'hFF);

        // Per-digit enable and decimal point over one full scan
        applyStimulus(32'h76543210, 8'h04, 8'h05, 2'd3, 1'b0);
        pulseLoad();
        measureWindow(128);
        checkLows("en05", 8'h05, 8'h04);

        // Leading-zero blanking (digit 3 carries a dp and is still blanked)
        applyStimulus(32'h00000305, 8'h08, 8'hFF, 2'd3, 1'b1);
        pulseLoad();
        measureWindow(128);
`ifdef SEV_SEG_LZB_EN
        checkLows("lzb", 8'h07, 8'h00);
`else
        checkLows("nolzb", 8'hFF, 8'h08);
`endif
        applyStimulus(32'h00000000, 8'h00, 8'hFF, 2'd3, 1'b1);
        pulseLoad();
        measureWindow(128);
`ifdef SEV_SEG_LZB_EN
        checkLows("lzb0", 8'h01, 8'h00);
`else
        checkLows("nolzb0", 8'hFF, 8'h00);
`endif

        // Asynchronous reset in the middle of digit 5
        applyStimulus(32'h76543210, 8'h00, 8'hFF, 2'd3, 1'b0);
        applyReset(1'b1);
        stepTo(1);
        load = 1'b0;
        stepTo(89);
        checkOutput("mid_an", an, 8'hDF);
        checkOutput("mid_seg", seg, 7'h12);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("async_an", an, 8'hFF);
        checkOutput("async_seg", seg, 7'h7F);
        checkOutput("async_dp", dp, 1'b1);
        checkOutput("async_frame", frame, 1'b0);
        applyReset(1'b0);
        stepTo(20);
        checkOutput("post_an", an, 8'hFF);
        checkOutput("post_seg", seg, 7'h7F);
        stepTo(127);
        checkOutput("post_e127_frame", frame, 1'b0);
        stepTo(128);
        checkOutput("post_e128_frame", frame, 1'b1);
        pulseLoad();
        stepTo(131);
        checkOutput("post_load_an", an, 8'hFE);
        checkOutput("post_load_seg", seg, 7'h40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
